shift_deserializer: RTL and testbench
=====================================

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter WIDTH, default 5: number of bits per assembled word.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 bit_in  input  1  serial data bit.
REQ-005 bit_valid  input  1  bit_in carries a valid bit this cycle.
REQ-006 right  input  1  word direction request: LSB-first (register shifts right, new bit enters at MSB).
REQ-007 left  input  1  word direction request: MSB-first (register shifts left, new bit enters at LSB).
REQ-008 flush  input  1  synchronous discard of the partial word and clear of overrun.
REQ-009 out_ready  input  1  consumer accepts out_value this cycle.
REQ-010 out_value  output  WIDTH  last completed word, registered.
REQ-011 out_valid  output  1  out_value holds an unconsumed word.
REQ-012 overrun  output  1  sticky; a completed word was dropped.
REQ-013 busy  output  1  high while a partial word is in progress (state SHIFT).

Function
REQ-014 The block SHALL have two states, IDLE and SHIFT, plus an internal WIDTH-bit shift register and a bit counter of width clog2(WIDTH+1).
REQ-015 In IDLE with bit_valid=1, the block SHALL latch direction: right=1 selects LSB-first (right has priority when both are high); right=0, left=1 selects MSB-first; both low discards the bit and stays in IDLE.
REQ-016 On an accepted first bit, the block SHALL shift it in per the latched direction, set the count to 1, and enter SHIFT.
REQ-017 In SHIFT, right and left SHALL be ignored; each bit_valid=1 SHALL shift one bit in per the latched direction and increment the count; bit_valid=0 SHALL hold all state.
REQ-018 MSB-first shift SHALL be sr <= {sr[WIDTH-2:0], bit_in}; LSB-first SHALL be sr <= {bit_in, sr[WIDTH-1:1]}.
REQ-019 On the edge accepting the WIDTH-th bit, the block SHALL compute the completed word (including that bit), clear the count, and return to IDLE; the next bit_valid SHALL start a new word with no gap cycle.
REQ-020 On completion, if out_valid=0 or out_ready=1 on the same edge, out_value SHALL load the completed word and out_valid SHALL be 1 from the next cycle (latency: one cycle after the last bit is sampled).
REQ-021 On completion with out_valid=1 and out_ready=0, the word SHALL be dropped, out_value/out_valid SHALL remain unchanged, and overrun SHALL be set.
REQ-022 out_valid=1 with out_ready=1 and no completion SHALL clear out_valid at that edge; out_value SHALL retain its last value.
REQ-023 out_ready with out_valid=0 SHALL have no effect.
REQ-024 flush=1 SHALL clear the shift register, the count, and overrun, and force IDLE; flush SHALL take priority over a same-cycle bit_valid (bit discarded, no completion) and SHALL NOT alter out_value or out_valid.
REQ-025 overrun SHALL remain 1 until flush or reset.
REQ-026 busy SHALL equal (state == SHIFT).

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force IDLE, shift register 0, count 0, out_value 0, out_valid 0, overrun 0, busy 0.
REQ-028 Reset asserted mid-word SHALL discard the partial word; after release, the first accepted bit SHALL start a new word.

Verification
REQ-029 Reset: drive rst_n=0 between clock edges -> all outputs 0 before the next edge; hold for 2 cycles, release -> outputs stay 0 with no input activity.
REQ-030 MSB-first: left=1, right=0, bits 1,0,1,1,0 on consecutive cycles -> out_value=5'b10110 and out_valid=1 in the cycle after the 5th bit; busy high during bits 2-5 only.
REQ-031 LSB-first with direction change: right=1 on first bit, then right=0, left=1; bits 1,0,1,1,0 -> out_value=5'b01101.
REQ-032 Backpressure: out_ready=0, send MSB-first 5'b00011 then 5'b11100 back-to-back -> out_value=5'b00011, overrun=1; pulse out_ready -> out_valid=0; flush -> overrun=0.
REQ-033 Flush and gaps: 3 bits, then flush with bit_valid=1 in the same cycle, then 5'b10101 MSB-first with random bit_valid gaps -> out_value=5'b10101 and no earlier word.
REQ-034 Async reset after 4 bits of a word -> outputs 0 at once; then a full word 5'b11001 MSB-first -> out_value=5'b11001.

Source files
------------

// File: rtl/shift_deserializer.sv
// Serial-to-parallel word assembler with per-word direction, a one-deep output register and a
// sticky overrun flag for words completed while the previous one is still unconsumed.
module shift_deserializer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             right,
  input  logic             left,
  input  logic             flush,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              lsb_first_q, lsb_first_d;
  logic [WIDTH-1:0]  out_value_q, out_value_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;

  logic              accept;
  logic              dir_lsb;
  logic [WIDTH-1:0]  shifted;
  logic [CntW-1:0]   cnt_inc;
  logic              complete;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    lsb_first_d = lsb_first_q;
    out_value_d = out_value_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    complete    = 1'b0;

    // Direction is only sampled on the first bit of a word; right wins a tie.
    accept  = bit_valid && ((state_q == StShift) || right || left);
    dir_lsb = (state_q == StIdle) ? right : lsb_first_q;
    shifted = dir_lsb ? {bit_in, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], bit_in};
    cnt_inc = cnt_q + 1'b1;

    if (flush) begin
      sr_d      = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
      state_d   = StIdle;
    end else if (accept) begin
      sr_d        = shifted;
      lsb_first_d = dir_lsb;
      if (cnt_inc == CntW'(WIDTH)) begin
        complete = 1'b1;
        cnt_d    = '0;
        state_d  = StIdle;
      end else begin
        cnt_d   = cnt_inc;
        state_d = StShift;
      end
    end

    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_value_d = shifted;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      cnt_q       <= '0;
      lsb_first_q <= 1'b0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      lsb_first_q <= lsb_first_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_value = out_value_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == StShift);

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: a driver pushes expected words into a queue and a
// monitor pops and compares them on every output handshake.
module tb_shift_deserializer;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       right;
  logic       left;
  logic       flush;
  logic       out_ready;
  logic [4:0] out_value;
  logic       out_valid;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  int pushed = 0;
  logic [4:0] exp_q[$];

  shift_deserializer #(.WIDTH(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .right     (right),
    .left      (left),
    .flush     (flush),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_valid (out_valid),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " out_value"}, int'(out_value), 0);
    check({name, " out_valid"}, int'(out_valid), 0);
    check({name, " overrun"}, int'(overrun), 0);
    check({name, " busy"}, int'(busy), 0);
  endtask

  // Monitor: every accepted output word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [4:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %b expected none", out_value);
      end else begin
        e = exp_q.pop_front();
        popped++;
        if (out_value !== e) begin
          errors++;
          $display("FAIL word: got %b expected %b", out_value, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one 5-bit word starting from IDLE; w[i] is the i-th bit sent in LSB-first mode.
  task automatic send_word(input logic [4:0] w, input bit lsb, input bit gaps, input bit load);
    if (load) begin
      exp_q.push_back(w);
      pushed++;
    end
    for (int i = 0; i < 5; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          bit_valid = 1'b0;
          right     = 1'b0;
          left      = 1'b0;
          tick();
        end
      end
      check("busy_before_bit", int'(busy), (i != 0) ? 1 : 0);
      bit_valid = 1'b1;
      bit_in    = lsb ? w[i] : w[4-i];
      right     = lsb && (i == 0);
      left      = !(lsb && (i == 0));
      tick();
    end
    bit_valid = 1'b0;
    right     = 1'b0;
    left      = 1'b0;
    check("busy_after_word", int'(busy), 0);
    if (load) begin
      check("out_valid_latency", int'(out_valid), 1);
      check("out_value_latency", int'(out_value), int'(w));
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    right     = 1'b0;
    left      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset asserted between edges must clear outputs without a clock.
    #3 rst_n = 1'b0;
    #1 check_all_zero("reset_async");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_all_zero("reset_release");

    send_word(5'b10110, 1'b0, 1'b0, 1'b1);
    send_word(5'b01101, 1'b1, 1'b0, 1'b1);
    tick();
    check("valid_cleared_after_consume", int'(out_valid), 0);

    // Backpressure: second word is dropped and flagged.
    out_ready = 1'b0;
    send_word(5'b00011, 1'b0, 1'b0, 1'b1);
    send_word(5'b11100, 1'b0, 1'b0, 1'b0);
    check("bp_overrun", int'(overrun), 1);
    check("bp_value_kept", int'(out_value), 5'b00011);
    check("bp_valid_kept", int'(out_valid), 1);
    tick();
    check("overrun_sticky", int'(overrun), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_valid_after_pulse", int'(out_valid), 0);
    check("bp_value_retained", int'(out_value), 5'b00011);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_clears_overrun", int'(overrun), 0);
    out_ready = 1'b1;

    // Partial word, then flush racing a valid bit.
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      left      = 1'b1;
      tick();
    end
    check("partial_busy", int'(busy), 1);
    flush  = 1'b1;
    bit_in = 1'b1;
    tick();
    flush     = 1'b0;
    bit_valid = 1'b0;
    left      = 1'b0;
    check("flush_idle", int'(busy), 0);
    check("flush_no_word", int'(out_valid), 0);
    send_word(5'b10101, 1'b0, 1'b1, 1'b1);
    tick();

    // Reset mid-word.
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      left      = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    left      = 1'b0;
    check("pre_reset_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_midword");
    tick();
    rst_n = 1'b1;
    tick();
    send_word(5'b11001, 1'b0, 1'b0, 1'b1);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    check("words_popped", popped, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
